// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scanner.
//   MAX_DIGITS : largest digit count the index width supports
//   SEG_TABLE  : active-high {g,f,e,d,c,b,a} pattern per hex nibble
//   scan_state_e : scanner FSM state encoding
package seven_seg_pkg;

    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        StIdle,
        StGap,
        StDrive
    } scan_state_e;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to seven-segment decoder (active-high).
//   nibble : hex digit 0..F
//   seg    : {g,f,e,d,c,b,a}, bit 0 = a, 1 = segment lit
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment display driver.
// Each rising edge of the (asynchronous) scan strobe advances one digit,
// with a dead-time gap of all anodes off between digits.
//   InputCLK     : system clock
//   nReset       : asynchronous active-low reset
//   ScanTick     : scan strobe, synchronized internally
//   Enable       : 1 = scan, 0 = display dark
//   Data         : hex nibble per digit, digit i = Data[4i+3:4i]
//   DP           : decimal point per digit
//   BlankMask    : 1 = digit kept dark while its slot elapses
//   Segments     : {g,f,e,d,c,b,a}
//   DecimalPoint : dp line
//   Anodes       : one-hot digit select
//   DigitIndex   : currently selected digit
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                  InputCLK,
    input  logic                  nReset,
    input  logic                  ScanTick,
    input  logic                  Enable,
    input  logic [4*DIGITS-1:0]   Data,
    input  logic [DIGITS-1:0]     DP,
    input  logic [DIGITS-1:0]     BlankMask,
    output logic [6:0]            Segments,
    output logic                  DecimalPoint,
    output logic [DIGITS-1:0]     Anodes,
    output logic [2:0]            DigitIndex
);

    localparam logic [6:0]        SegOff = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DpOff  = ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AnOff  = {DIGITS{ACTIVE_LOW}};
    localparam int unsigned       IdxW   = $clog2(MAX_DIGITS);

    scan_state_e           state_q;
    logic [IdxW-1:0]       idx_q;
    logic [7:0]            cnt_q;
    logic                  sync1_q, sync2_q, hist_q;
    logic [4*DIGITS-1:0]   data_sh_q;
    logic [DIGITS-1:0]     dp_sh_q;
    logic [DIGITS-1:0]     blank_sh_q;

    logic                  tick;
    logic                  last_digit;
    logic [IdxW-1:0]       idx_next;
    logic [3:0]            cur_nibble;
    logic [6:0]            seg_ah;
    logic [6:0]            seg_drive;
    logic                  dp_drive;
    logic [DIGITS-1:0]     an_drive;
    logic [DIGITS-1:0]     an_onehot;

    // One event per strobe rising edge, after the two-flop synchronizer.
    assign tick       = sync2_q & ~hist_q;
    assign last_digit = (idx_q == IdxW'(DIGITS - 1));
    assign idx_next   = last_digit ? '0 : idx_q + 1'b1;

    assign cur_nibble = data_sh_q[{idx_q, 2'b00} +: 4];

    hex_to_7seg u_dec (
        .nibble (cur_nibble),
        .seg    (seg_ah)
    );

    assign an_onehot = DIGITS'(1) << idx_q;

    // A masked digit is fully dark: anode, segments and dp all inactive.
    always_comb begin
        seg_drive = ACTIVE_LOW ? ~seg_ah : seg_ah;
        dp_drive  = ACTIVE_LOW ? ~dp_sh_q[idx_q] : dp_sh_q[idx_q];
        an_drive  = ACTIVE_LOW ? ~an_onehot : an_onehot;
        if (blank_sh_q[idx_q]) begin
            seg_drive = SegOff;
            dp_drive  = DpOff;
            an_drive  = AnOff;
        end
    end

    always_ff @(posedge InputCLK or negedge nReset) begin
        if (!nReset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            hist_q       <= 1'b0;
            data_sh_q    <= '0;
            dp_sh_q      <= '0;
            blank_sh_q   <= '0;
            Segments     <= SegOff;
            DecimalPoint <= DpOff;
            Anodes       <= AnOff;
        end else begin
            sync1_q <= ScanTick;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;

            if (!Enable) begin
                state_q      <= StIdle;
                idx_q        <= '0;
                Segments     <= SegOff;
                DecimalPoint <= DpOff;
                Anodes       <= AnOff;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (tick) begin
                            state_q    <= StGap;
                            idx_q      <= '0;
                            cnt_q      <= 8'(BLANK_CYCLES);
                            data_sh_q  <= Data;
                            dp_sh_q    <= DP;
                            blank_sh_q <= BlankMask;
                        end
                    end
                    StGap: begin
                        // Ticks here are ignored so the index never skips.
                        if (cnt_q == 8'd0) begin
                            state_q      <= StDrive;
                            Segments     <= seg_drive;
                            DecimalPoint <= dp_drive;
                            Anodes       <= an_drive;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    StDrive: begin
                        if (tick) begin
                            state_q      <= StGap;
                            idx_q        <= idx_next;
                            cnt_q        <= 8'(BLANK_CYCLES);
                            Segments     <= SegOff;
                            DecimalPoint <= DpOff;
                            Anodes       <= AnOff;
                            // New frame starts at digit 0: take a coherent snapshot.
                            if (last_digit) begin
                                data_sh_q  <= Data;
                                dp_sh_q    <= DP;
                                blank_sh_q <= BlankMask;
                            end
                        end
                    end
                    default: begin
                        state_q      <= StIdle;
                        Segments     <= SegOff;
                        DecimalPoint <= DpOff;
                        Anodes       <= AnOff;
                    end
                endcase
            end
        end
    end

    assign DigitIndex = idx_q;

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed driver for a common-anode multi-digit seven-segment display. Consumes the slow scan strobe produced by the frequency generator stage (typically configured at about 1 kHz) and, on each strobe rising edge, advances one digit: it decodes that digit's hex nibble and drives segment and anode lines with a dead-time gap to prevent ghosting. It sits between the SoC's display data registers and the board pins.

## Interface
- `DIGITS`, 8: number of digits scanned (2..8).
- `BLANK_CYCLES`, 16: InputCLK cycles with all anodes off between digits (0..255).
- `ACTIVE_LOW`, 1: 1 = segment, decimal-point and anode outputs are active-low; 0 = active-high.
- `InputCLK`  input  1  system clock; the only clock.
- `nReset`  input  1  reset, asynchronous assert, active-low.
- `ScanTick`  input  1  scan strobe (level signal from the frequency generator); treated as asynchronous and synchronized internally.
- `Enable`  input  1  1 = scan; 0 = display dark.
- `Data`  input  4*DIGITS  hex nibble per digit; digit i = `Data[4i+3:4i]`.
- `DP`  input  DIGITS  decimal point per digit.
- `BlankMask`  input  DIGITS  1 = digit i dark (anode never asserted) while its slot still elapses.
- `Segments`  output  7  {g,f,e,d,c,b,a}; bit 0 = a.
- `DecimalPoint`  output  1  dp line.
- `Anodes`  output  DIGITS  one-hot digit select.
- `DigitIndex`  output  3  digit currently selected (debug/status).

## Operation
- Reset values: `Segments`, `DecimalPoint` and `Anodes` are all inactive (all ones when ACTIVE_LOW=1); `DigitIndex`=0; state IDLE. Shadow registers are cleared.
- ScanTick passes through a 2-flop synchronizer plus one history flop. Tick event = synchronized high AND history low, i.e. one event per rising edge only.
- States:
  - IDLE: outputs inactive. A tick event with Enable=1 goes to GAP with index 0.
  - GAP: anodes and segments inactive; gap counter counts down from BLANK_CYCLES. When the counter is 0, go to DRIVE.
  - DRIVE: drives decode(shadow nibble[index]), shadow DP[index], and anode[index] unless shadow BlankMask[index]=1. A tick event goes to GAP with index+1, wrapping from DIGITS-1 to 0.
- Frame coherence: on every entry to GAP with index 0, `Data`, `DP` and `BlankMask` are captured into shadow registers. Input changes mid-frame take effect at the next frame.
- BLANK_CYCLES=0: GAP lasts exactly 1 cycle.
- Tick events arriving while in GAP are ignored; the index does not skip. Legal tick period is at least BLANK_CYCLES+6 InputCLK cycles.
- Enable=0 in any state: the next edge goes to IDLE, outputs go inactive, and index is set to 0. Re-enable waits for the next tick event.
- Asynchronous reset mid-scan forces reset values immediately, with no glitch to an active anode.
- Decode (active-high form; bitwise invert when ACTIVE_LOW=1): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.

## Timing
- ScanTick first sampled high at InputCLK edge N → anodes go inactive (GAP entry) at edge N+2.
- New anode and segments become valid at edge N+2+BLANK_CYCLES+1. Segments and anode change on the same edge.
- All outputs are registered; there is no combinational path from inputs to pins.
- Frame period = DIGITS × tick period.
- Enable fall → outputs inactive 1 edge later.

## Structure
- Package `seven_seg_pkg`: the 16-entry segment pattern constant table, the state encoding (IDLE/GAP/DRIVE), and the max DIGITS constant.
- Sub-module `hex_to_7seg`: combinational nibble→7-bit active-high decoder. Output polarity inversion is applied in the parent before the output register.
- Synchronizer and edge detector are inline in the parent.

## Test plan
- Reset then Enable=1, ACTIVE_LOW=1, Data=32'h76543210, one tick → after GAP, Anodes=8'hFE, Segments=7'h40 (digit "0"); DigitIndex=0.
- Eight ticks → Anodes walks FE, FD, … 7F then wraps to FE. Each transition shows exactly BLANK_CYCLES+1 cycles with Anodes=FF, and never two anodes active at once.
- Change Data to 32'hFFFFFFFF while index=3 → digits 3..7 still show the old values; after the wrap, digit 0 shows 7'h0E ("F" inverted).
- BlankMask=8'h02, DP=8'h02 → in slot 1 Anodes stays FF for the whole slot; index still advances to 2 on the next tick.
- Drop Enable during DRIVE → next edge Anodes=FF and DigitIndex=0. Ticks while Enable=0 cause no activity; re-enable resumes at digit 0.
- Assert nReset between clock edges during DRIVE → outputs go inactive immediately, before the next edge. Deassert and one tick → digit 0 is shown with a freshly captured frame.
